// File: rtl/writeback_ctrl.sv
// writeback_ctrl: register-file writer and hazard scoreboard.
// Tracks in-flight writes to 16 registers, stalls issue on RAW/WAW hazards,
// buffers in-order results in a 2-entry FIFO and commits one per cycle.
// Optional build macro: WB_BYPASS_EN. It lets a source or destination that
// matches the register committing this cycle issue without a stall, and it
// drives FWD_A/FWD_B.
module writeback_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ISS_VALID,
    input  logic [3:0] ISS_A,
    input  logic       ISS_USE_A,
    input  logic [3:0] ISS_B,
    input  logic       ISS_USE_B,
    input  logic [3:0] ISS_W,
    input  logic       ISS_WEN,
    output logic       ISS_READY,
    input  logic       RES_VALID,
    input  logic [3:0] RES_W,
    input  logic [7:0] RES_DATA,
    output logic       RES_READY,
    output logic [3:0] W,
    output logic       Write,
    output logic [7:0] DATA,
    output logic       FWD_A,
    output logic       FWD_B,
    output logic       IDLE
);

    logic [15:0] r_pend;
    logic [1:0]  r_cnt;
    logic [3:0]  r_q0_w;
    logic [7:0]  r_q0_d;
    logic [3:0]  r_q1_w;
    logic [7:0]  r_q1_d;

    logic        w_commit;
    logic        w_push;
    logic        w_hazard;
    logic        w_accept;
    logic [15:0] w_clr;
    logic [15:0] w_set;
    logic [15:0] w_pend_chk;

    // Commit, FIFO handshake and scoreboard set/clear masks
    always_comb begin
        w_commit = (r_cnt != 2'd0);
        w_push   = RES_VALID & RES_READY;
        w_clr    = w_commit ? (16'd1 << r_q0_w) : 16'd0;
`ifdef WB_BYPASS_EN
        // The committing register's value is on DATA this cycle, so it no
        // longer blocks issue.
        w_pend_chk = r_pend & ~w_clr;
`else
        w_pend_chk = r_pend;
`endif
        w_hazard = (ISS_USE_A & w_pend_chk[ISS_A]) |
                   (ISS_USE_B & w_pend_chk[ISS_B]) |
                   (ISS_WEN   & w_pend_chk[ISS_W]);
        w_accept = ISS_VALID & ~w_hazard;
        w_set    = (w_accept & ISS_WEN) ? (16'd1 << ISS_W) : 16'd0;
    end

    // Output decode from registered state and the issue inputs
    always_comb begin
        ISS_READY = ~w_hazard;
        RES_READY = (r_cnt < 2'd2);
        Write     = w_commit;
        W         = w_commit ? r_q0_w : 4'd0;
        DATA      = w_commit ? r_q0_d : 8'd0;
        IDLE      = (r_pend == 16'd0) & (r_cnt == 2'd0);
`ifdef WB_BYPASS_EN
        FWD_A     = w_commit & ISS_USE_A & (ISS_A == r_q0_w);
        FWD_B     = w_commit & ISS_USE_B & (ISS_B == r_q0_w);
`else
        FWD_A     = 1'b0;
        FWD_B     = 1'b0;
`endif
    end

    // Scoreboard update: a set in the same cycle as a clear wins
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_pend <= 16'd0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    // Result FIFO: entry 0 is always the head, so a pop shifts entry 1 down
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_cnt  <= 2'd0;
            r_q0_w <= 4'd0;
            r_q0_d <= 8'd0;
            r_q1_w <= 4'd0;
            r_q1_d <= 8'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_q0_w <= RES_W;
                        r_q0_d <= RES_DATA;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    // The head always commits here; a push replaces it
                    if (w_push) begin
                        r_q0_w <= RES_W;
                        r_q0_d <= RES_DATA;
                    end else begin
                        r_cnt  <= 2'd0;
                    end
                end
                default: begin
                    // Full: no push is accepted, the head pops
                    r_q0_w <= r_q1_w;
                    r_q0_d <= r_q1_d;
                    r_cnt  <= 2'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Testbench for writeback_ctrl: directed scenarios followed by random
// stimulus, every output compared each cycle against a queue-based model.
module tb_writeback_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       ISS_VALID = 1'b0;
    logic [3:0] ISS_A = 4'd0;
    logic       ISS_USE_A = 1'b0;
    logic [3:0] ISS_B = 4'd0;
    logic       ISS_USE_B = 1'b0;
    logic [3:0] ISS_W = 4'd0;
    logic       ISS_WEN = 1'b0;
    logic       ISS_READY;
    logic       RES_VALID = 1'b0;
    logic [3:0] RES_W = 4'd0;
    logic [7:0] RES_DATA = 8'd0;
    logic       RES_READY;
    logic [3:0] W;
    logic       Write;
    logic [7:0] DATA;
    logic       FWD_A;
    logic       FWD_B;
    logic       IDLE;

    writeback_ctrl dut (
        .CLK(CLK), .RST(RST),
        .ISS_VALID(ISS_VALID), .ISS_A(ISS_A), .ISS_USE_A(ISS_USE_A),
        .ISS_B(ISS_B), .ISS_USE_B(ISS_USE_B), .ISS_W(ISS_W), .ISS_WEN(ISS_WEN),
        .ISS_READY(ISS_READY),
        .RES_VALID(RES_VALID), .RES_W(RES_W), .RES_DATA(RES_DATA),
        .RES_READY(RES_READY),
        .W(W), .Write(Write), .DATA(DATA),
        .FWD_A(FWD_A), .FWD_B(FWD_B), .IDLE(IDLE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] w;
        logic [7:0] d;
    } res_t;

    res_t m_q[$];
    bit   m_pend[16];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model exactly as the rising edge will advance the DUT.
    task automatic cycle(input logic rst, input logic iv,
                         input logic [3:0] a, input logic ua,
                         input logic [3:0] b, input logic ub,
                         input logic [3:0] w, input logic wen,
                         input logic rv, input logic [3:0] rw, input logic [7:0] rd);
        bit         e_write, busy_a, busy_b, busy_w, e_hz, e_idle;
        logic [3:0] e_w;
        logic [7:0] e_d;
        bit         e_fa, e_fb;
        @(negedge CLK);
        RST = rst; ISS_VALID = iv; ISS_A = a; ISS_USE_A = ua; ISS_B = b;
        ISS_USE_B = ub; ISS_W = w; ISS_WEN = wen;
        RES_VALID = rv; RES_W = rw; RES_DATA = rd;
        #1;
        e_write = (m_q.size() > 0);
        e_w     = e_write ? m_q[0].w : 4'd0;
        e_d     = e_write ? m_q[0].d : 8'd0;
        busy_a  = m_pend[a];
        busy_b  = m_pend[b];
        busy_w  = m_pend[w];
        e_fa    = 1'b0;
        e_fb    = 1'b0;
`ifdef WB_BYPASS_EN
        if (e_write) begin
            if (a == e_w) busy_a = 1'b0;
            if (b == e_w) busy_b = 1'b0;
            if (w == e_w) busy_w = 1'b0;
            e_fa = ua && (a == e_w);
            e_fb = ub && (b == e_w);
        end
`endif
        e_hz   = (ua && busy_a) || (ub && busy_b) || (wen && busy_w);
        e_idle = (m_q.size() == 0);
        foreach (m_pend[i]) if (m_pend[i]) e_idle = 1'b0;

        chk("iss_ready", {7'd0, ISS_READY}, {7'd0, !e_hz});
        chk("res_ready", {7'd0, RES_READY}, {7'd0, m_q.size() < 2});
        chk("write",     {7'd0, Write},     {7'd0, e_write});
        chk("w",         {4'd0, W},         {4'd0, e_w});
        chk("data",      DATA,              e_d);
        chk("fwd_a",     {7'd0, FWD_A},     {7'd0, e_fa});
        chk("fwd_b",     {7'd0, FWD_B},     {7'd0, e_fb});
        chk("idle",      {7'd0, IDLE},      {7'd0, e_idle});

        if (!rst) begin
            model_reset();
        end else begin
            bit do_push;
            do_push = rv && (m_q.size() < 2);
            if (e_write) begin
                m_pend[m_q[0].w] = 1'b0;
                void'(m_q.pop_front());
            end
            if (iv && !e_hz && wen) m_pend[w] = 1'b1;
            if (do_push) m_q.push_back('{w: rw, d: rd});
        end
    endtask

    task automatic idle_cycle();
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    initial begin
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        model_reset();

        // Reset values
        cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        idle_cycle();

        // Issue a write to r5, then a reader of r5 stalls until the commit
        cycle(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 8'd0);
        cycle(1'b1, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        cycle(1'b1, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 8'h3C);
        cycle(1'b1, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        cycle(1'b1, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0);

        // WAW on r9: stall, commit, then re-issue sets r9 again
        cycle(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 4'd0, 8'd0);
        cycle(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1, 4'd9, 8'hA5);
        cycle(1'b1, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 8'd0);
        cycle(1'b1, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 8'd0);
        cycle(1'b1, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 8'h11);
        idle_cycle();
        idle_cycle();

        // Same register set and cleared in one cycle (r3)
        cycle(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd3, 8'h77);
        cycle(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 8'd0);
        cycle(1'b1, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 8'h42);
        idle_cycle();

        // Back-to-back pushes drain one per cycle
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 8'h01);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 8'h02);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 8'h03);
        idle_cycle();

        // Reset in the middle of activity (r0 and r5 pending, FIFO busy)
        cycle(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd7, 8'h55);
        cycle(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd8, 8'h66);
        cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 8'h99);
        idle_cycle();

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] ra, rb, rw, rr;
            bit         wide;
            wide = ($urandom_range(0, 7) == 0);
            ra = wide ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            rb = wide ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            rw = wide ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            rr = wide ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            cycle($urandom_range(0, 49) != 0,
                  1'($urandom), ra, 1'($urandom), rb, 1'($urandom),
                  rw, 1'($urandom),
                  1'($urandom), rr, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
